// File: rtl/hamming_enco_stream_if.sv
// Block-in / codeword-out bus of the Hamming(21,16) stream encoder.
// Both channels transfer on a clock edge where valid and ready are both high; valid never depends on ready.
interface hamming_enco_stream_if #(
    parameter int NUM_WORDS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:16*NUM_WORDS]  in_data;
    logic [1:5]             inj_pos;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:21]            out_code;
    logic                   out_last;
    logic                   state_dbg;

    modport master (
        output in_valid, in_data, inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_last, state_dbg
    );

    modport slave (
        input  in_valid, in_data, inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_last, state_dbg
    );
endinterface

// File: rtl/hamming_enco_stream.sv
// Splits a latched block into 16-bit words and emits one registered even-parity
// Hamming(21,16) codeword per word, with an optional per-block single-bit flip.
module hamming_enco_stream #(
    parameter int NUM_WORDS = 4
) (
    input logic                   clk,
    input logic                   rst,
    hamming_enco_stream_if.slave  bus
);
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BW = 16 * NUM_WORDS;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:BW]     blk_q, blk_d;
    logic [1:5]      inj_q, inj_d;
    logic [1:21]     code_q, code_d;

    // Index of every vector is the Hamming position, so parity lists read straight off the position bits.
    function automatic logic [1:21] encode(input logic [1:16] d, input logic [1:5] inj);
        logic [1:21] c;
        c        = '0;
        c[3]     = d[1];
        c[5:7]   = d[2:4];
        c[9:15]  = d[5:11];
        c[17:21] = d[12:16];
        c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15] ^ c[17] ^ c[19] ^ c[21];
        c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15] ^ c[18] ^ c[19];
        c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15] ^ c[20] ^ c[21];
        c[8]  = ^c[9:15];
        c[16] = ^c[17:21];
        for (int p = 1; p <= 21; p++) begin
            if (int'(inj) == p) c[p] = ~c[p];
        end
        return c;
    endfunction

    function automatic logic [1:16] select_word(input logic [1:BW] blk, input logic [CW-1:0] idx);
        logic [1:16] w;
        w = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx == CW'(i)) w = blk[1+16*i +: 16];
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            inj_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            inj_q   <= inj_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        inj_d   = inj_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.in_data;
                    inj_d   = bus.inj_pos;
                    cnt_d   = '0;
                    code_d  = encode(bus.in_data[1:16], bus.inj_pos);
                    state_d = SEND;
                end
            end
            SEND: begin
                // Without a handshake nothing moves, which keeps the codeword stable under backpressure.
                if (bus.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        code_d = encode(select_word(blk_q, cnt_q + 1'b1), inj_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == SEND);
        bus.out_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
        bus.out_code  = code_q;
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_hamming_enco_stream.sv
// Self-checking bench for hamming_enco_stream: fixed vectors, backpressure and reset
// sequences, then random blocks checked against a generic Hamming encode/decode model.
module tb_hamming_enco_stream;
    localparam int NW = 4;
    localparam int NUM_RAND = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hamming_enco_stream_if #(.NUM_WORDS(NW)) bus ();
    hamming_enco_stream #(.NUM_WORDS(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    int n_last = 0;

    logic [20:0] exp_q[$];
    logic [15:0] exp_word_q[$];
    logic        exp_last_q[$];

    typedef struct {
        logic [63:0]       blk;
        logic [4:0]        inj;
        logic [3:0][20:0]  exp;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Generic rule: data fills non-power-of-two positions in order; parity 2^k covers positions with bit k set.
    function automatic logic [20:0] model_encode(input logic [15:0] word, input logic [4:0] inj);
        logic [20:0] c;
        logic        par;
        int          di;
        c  = '0;
        di = 15;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[21-p] = word[di];
                di--;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) if (p[k]) par ^= c[21-p];
            c[21-(1<<k)] = par;
        end
        if (inj >= 1 && inj <= 21) c[21-inj] = ~c[21-inj];
        return c;
    endfunction

    function automatic logic [15:0] model_decode(input logic [20:0] code);
        logic [20:0] c;
        logic [15:0] w;
        int          s;
        int          di;
        c  = code;
        s  = 0;
        for (int p = 1; p <= 21; p++) if (c[21-p]) s ^= p;
        if (s >= 1 && s <= 21) c[21-s] = ~c[21-s];
        w  = '0;
        di = 15;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[di] = c[21-p];
                di--;
            end
        end
        return w;
    endfunction

    task automatic run_vector(input vec_t v, input string tag);
        check({tag, ".in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_data   = v.blk;
        bus.inj_pos   = v.inj;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int w = 0; w < NW; w++) begin
            check($sformatf("%s.w%0d.code", tag, w), bus.out_code, v.exp[w]);
            check($sformatf("%s.w%0d.valid", tag, w), bus.out_valid, 1'b1);
            check($sformatf("%s.w%0d.last", tag, w), bus.out_last, (w == NW - 1));
            check($sformatf("%s.w%0d.in_ready", tag, w), bus.in_ready, 1'b0);
            @(negedge clk);
        end
        check({tag, ".valid_after"}, bus.out_valid, 1'b0);
        check({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] blk;
        logic [4:0]  inj;
        logic [20:0] got;
        logic        accepted;
        int          budget;

        tbl[0] = '{64'h0000_0000_0000_0000, 5'd0,  {21'h000000, 21'h000000, 21'h000000, 21'h000000}};
        tbl[1] = '{64'hFFFF_8000_0000_FFFF, 5'd0,  {21'h0FFFFF, 21'h000000, 21'h1C0000, 21'h0FFFFF}};
        tbl[2] = '{64'h0000_0000_0000_0000, 5'd5,  {21'h010000, 21'h010000, 21'h010000, 21'h010000}};
        tbl[3] = '{64'h0000_0000_0000_0000, 5'd25, {21'h000000, 21'h000000, 21'h000000, 21'h000000}};
        tbl[4] = '{64'h0000_0000_0000_0000, 5'd21, {21'h000001, 21'h000001, 21'h000001, 21'h000001}};
        tbl[5] = '{64'h0000_0000_0000_0000, 5'd1,  {21'h100000, 21'h100000, 21'h100000, 21'h100000}};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inj_pos   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready", bus.in_ready, 1'b1);
        check("reset.out_valid", bus.out_valid, 1'b0);
        check("reset.out_last", bus.out_last, 1'b0);
        check("reset.out_code", bus.out_code, 21'h000000);

        for (int i = 0; i < 6; i++) run_vector(tbl[i], $sformatf("vec%0d", i));

        // Stall on word 1 while a competing block is offered and must be ignored.
        bus.in_valid  = 1'b1;
        bus.in_data   = tbl[1].blk;
        bus.inj_pos   = 5'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.w0.code", bus.out_code, 21'h0FFFFF);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hDEAD_BEEF_1234_5678;
        bus.inj_pos   = 5'd3;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.stall%0d.code", i), bus.out_code, 21'h1C0000);
            check($sformatf("bp.stall%0d.valid", i), bus.out_valid, 1'b1);
            check($sformatf("bp.stall%0d.last", i), bus.out_last, 1'b0);
            check($sformatf("bp.stall%0d.in_ready", i), bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 1; w < NW; w++) begin
            check($sformatf("bp.w%0d.code", w), bus.out_code, tbl[1].exp[w]);
            check($sformatf("bp.w%0d.last", w), bus.out_last, (w == NW - 1));
            @(negedge clk);
        end
        check("bp.valid_after", bus.out_valid, 1'b0);
        check("bp.in_ready_after", bus.in_ready, 1'b1);

        // Reset while word 2 is on the bus abandons the block.
        bus.in_valid = 1'b1;
        bus.in_data  = tbl[1].blk;
        bus.inj_pos  = 5'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid.w2.code", bus.out_code, tbl[1].exp[2]);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.out_valid", bus.out_valid, 1'b0);
        check("rst_mid.in_ready", bus.in_ready, 1'b1);
        check("rst_mid.out_last", bus.out_last, 1'b0);
        check("rst_mid.out_code", bus.out_code, 21'h000000);
        repeat (2) @(negedge clk);
        check("rst_mid.quiet", bus.out_valid, 1'b0);
        run_vector(tbl[1], "rst_mid.new");

        for (int b = 0; b < NUM_RAND; b++) begin
            blk = {$urandom, $urandom};
            inj = 5'($urandom_range(0, 31));
            for (int w = 0; w < NW; w++) begin
                exp_q.push_back(model_encode(blk[63-16*w -: 16], inj));
                exp_word_q.push_back(blk[63-16*w -: 16]);
                exp_last_q.push_back(w == NW - 1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = blk;
            bus.inj_pos  = inj;
            budget = 0;
            while ((bus.in_valid || exp_q.size() != 0) && budget < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rand.spurious_codeword", bus.out_valid, 1'b0);
                    end else begin
                        got = bus.out_code;
                        check($sformatf("rand.b%0d.code", b), got, exp_q.pop_front());
                        check($sformatf("rand.b%0d.decode", b), model_decode(got), exp_word_q.pop_front());
                        check($sformatf("rand.b%0d.last", b), bus.out_last, exp_last_q.pop_front());
                    end
                    if (bus.out_last) n_last++;
                end
                accepted = bus.in_valid && bus.in_ready;
                @(negedge clk);
                budget++;
                if (accepted) bus.in_valid = 1'b0;
            end
            if (budget >= 200) begin
                check($sformatf("rand.b%0d.timeout", b), 1'b1, 1'b0);
                bus.in_valid = 1'b0;
                exp_q.delete();
                exp_word_q.delete();
                exp_last_q.delete();
            end
        end
        check("rand.last_count", n_last, NUM_RAND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
